gb_frame_sequencer: RTL and testbench

APU frame sequencer: divides the system clock down to 512 Hz step events. It walks an 8-step sequence and emits the single-cycle `clk_length_ctr`, `clk_sweep` and `clk_vol_env` strobes that drive the pulse, wave and noise channels. It sits directly upstream of every sound channel and is the only source of those three strobes. It also models the DIV-write side effect on the sequencer.

---
 rtl/gb_apu_pkg.sv | 17 +
 rtl/gb_frame_sequencer.sv | 77 +++++++
 tb/tb_gb_frame_sequencer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/gb_apu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gb_apu_pkg
//  Description : Shared APU constants: frame-sequencer divider and step masks.
//  Revision    : 1.0 - initial release
// ============================================================================
package gb_apu_pkg;

    localparam int FS_CLK_DIV_DEFAULT = 8192;

    // Bit n set means step n emits that strobe.
    localparam logic [7:0] FS_LEN_STEPS   = 8'b0101_0101;
    localparam logic [7:0] FS_SWEEP_STEPS = 8'b0100_0100;
    localparam logic [7:0] FS_ENV_STEPS   = 8'b1000_0000;

endpackage
`default_nettype wire

// File: rtl/gb_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : gb_frame_sequencer
//  Description : APU frame sequencer - 512 Hz step events, length/sweep/env
//                strobes, and the DIV-write falling-bit side effect.
//  Revision    : 1.0 - initial release
// ============================================================================
module gb_frame_sequencer
    import gb_apu_pkg::*;
#(
    parameter int CLK_DIV = FS_CLK_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       apu_enable,
    input  logic       div_write,
    output logic       clk_length_ctr,
    output logic       clk_sweep,
    output logic       clk_vol_env,
    output logic [2:0] step,
    output logic       length_phase
);

    localparam int                 CNT_W     = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0]   C_CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_step;
    logic             r_len;
    logic             r_sweep;
    logic             r_env;

    logic w_wrap;
    logic w_div_fall;
    logic w_event;

    // A DIV write clearing a set MSB looks like a falling edge to the APU;
    // OR-ing with the wrap keeps a coincident write to a single event.
    assign w_wrap     = (r_cnt == C_CNT_MAX);
    assign w_div_fall = div_write & r_cnt[CNT_W-1];
    assign w_event    = w_wrap | w_div_fall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_step  <= 3'd0;
            r_len   <= 1'b0;
            r_sweep <= 1'b0;
            r_env   <= 1'b0;
        end else begin
            // DIV lives outside the APU, so the prescaler ignores apu_enable.
            r_cnt <= div_write ? '0 : r_cnt + CNT_W'(1);

            if (!apu_enable) begin
                r_step  <= 3'd0;
                r_len   <= 1'b0;
                r_sweep <= 1'b0;
                r_env   <= 1'b0;
            end else begin
                r_len   <= FS_LEN_STEPS[r_step]   & w_event;
                r_sweep <= FS_SWEEP_STEPS[r_step] & w_event;
                r_env   <= FS_ENV_STEPS[r_step]   & w_event;
                if (w_event) begin
                    r_step <= r_step + 3'd1;
                end
            end
        end
    end

    assign clk_length_ctr = r_len;
    assign clk_sweep      = r_sweep;
    assign clk_vol_env    = r_env;
    assign step           = r_step;
    assign length_phase   = r_step[0];

endmodule
`default_nettype wire

// File: tb/tb_gb_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gb_frame_sequencer
//  Description : Scoreboard bench for gb_frame_sequencer with CLK_DIV = 16.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gb_frame_sequencer;

    localparam int CLK_DIV = 16;

    typedef struct {
        logic       len;
        logic       sweep;
        logic       env;
        logic [2:0] step;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       apu_enable = 1'b1;
    logic       div_write = 1'b0;
    logic       clk_length_ctr;
    logic       clk_sweep;
    logic       clk_vol_env;
    logic [2:0] step;
    logic       length_phase;

    int   checks = 0;
    int   failures = 0;
    exp_t q[$];

    int   m_cnt = 0;
    int   m_step = 0;
    bit   m_len_last = 1'b0;
    int   n_len = 0;
    int   n_sweep = 0;
    int   n_env = 0;

    gb_frame_sequencer #(.CLK_DIV(CLK_DIV)) dut (
        .clk            (clk),
        .reset          (rst_n),
        .apu_enable     (apu_enable),
        .div_write      (div_write),
        .clk_length_ctr (clk_length_ctr),
        .clk_sweep      (clk_sweep),
        .clk_vol_env    (clk_vol_env),
        .step           (step),
        .length_phase   (length_phase)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a counter of clocks since the last clear, and a step index.
    always @(posedge clk or negedge rst_n) begin : model
        automatic bit   ev;
        automatic exp_t e;
        if (!rst_n) begin
            m_cnt      <= 0;
            m_step     <= 0;
            m_len_last <= 1'b0;
        end else begin
            ev = (m_cnt == CLK_DIV - 1) || (div_write && m_cnt >= CLK_DIV / 2);
            e.len   = apu_enable && ev && (m_step % 2 == 0);
            e.sweep = apu_enable && ev && (m_step == 2 || m_step == 6);
            e.env   = apu_enable && ev && (m_step == 7);
            e.step  = !apu_enable ? 3'd0 : (ev ? 3'((m_step + 1) % 8) : 3'(m_step));
            q.push_back(e);
            m_cnt      <= div_write ? 0 : (m_cnt + 1) % CLK_DIV;
            m_step     <= int'(e.step);
            m_len_last <= e.len;
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("len",   int'(clk_length_ctr), int'(e.len));
            chk("sweep", int'(clk_sweep),      int'(e.sweep));
            chk("env",   int'(clk_vol_env),    int'(e.env));
            chk("step",  int'(step),           int'(e.step));
            chk("phase", int'(length_phase),   int'(e.step[0]));
        end
        n_len   += int'(clk_length_ctr);
        n_sweep += int'(clk_sweep);
        n_env   += int'(clk_vol_env);
    end

    task automatic pulse_div_at(input int c);
        for (int i = 0; i < 64 && m_cnt != c; i++) @(negedge clk);
        chk("wait_cnt", m_cnt, c);
        div_write = 1'b1;
        @(negedge clk);
        div_write = 1'b0;
    endtask

    initial begin
        int s_len, s_sweep, s_env;

        #3;
        chk("rst_len",   int'(clk_length_ctr), 0);
        chk("rst_sweep", int'(clk_sweep), 0);
        chk("rst_env",   int'(clk_vol_env), 0);
        chk("rst_step",  int'(step), 0);
        chk("rst_phase", int'(length_phase), 0);

        // Scenario 1: one full 8-step period from reset release.
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        s_len = n_len; s_sweep = n_sweep; s_env = n_env;
        repeat (128) @(negedge clk);
        #1;
        chk("period_len",   n_len - s_len, 4);
        chk("period_sweep", n_sweep - s_sweep, 2);
        chk("period_env",   n_env - s_env, 1);
        chk("period_step",  int'(step), 0);

        // Scenario 2: disable at step 5 for 40 cycles.
        for (int i = 0; i < 200 && m_step != 5; i++) @(negedge clk);
        chk("wait_step5", m_step, 5);
        apu_enable = 1'b0;
        @(negedge clk);
        #1;
        s_len = n_len; s_sweep = n_sweep; s_env = n_env;
        repeat (39) @(negedge clk);
        #1;
        chk("off_strobes", (n_len - s_len) + (n_sweep - s_sweep) + (n_env - s_env), 0);
        apu_enable = 1'b1;
        repeat (40) @(negedge clk);

        // Scenarios 3-5: DIV writes above, below and at the wrap point.
        pulse_div_at(10);
        repeat (20) @(negedge clk);
        pulse_div_at(3);
        repeat (20) @(negedge clk);
        pulse_div_at(15);
        repeat (20) @(negedge clk);

        // Scenario 6: asynchronous reset in the middle of a length strobe.
        for (int i = 0; i < 200 && !m_len_last; i++) @(negedge clk);
        chk("wait_len", int'(m_len_last), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_len",   int'(clk_length_ctr), 0);
        chk("arst_step",  int'(step), 0);
        chk("arst_phase", int'(length_phase), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 63) == 0) apu_enable = ~apu_enable;
            div_write = ($urandom_range(0, 24) == 0);
            @(negedge clk);
        end
        div_write = 1'b0;
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
